// File: rtl/sha3_lane_serializer.sv
// Captures a full 5x5 Keccak state on a sample strobe and streams the first
// OUT_LANES lanes over a valid/ready handshake, flagging states it had to drop.
module sha3_lane_serializer #(
   parameter int OUT_LANES = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] isa [0:4],
   input  logic [63:0] isb [0:4],
   input  logic [63:0] isc [0:4],
   input  logic [63:0] isd [0:4],
   input  logic [63:0] ise [0:4],
   input  logic        sample,
   output logic        accept,
   output logic [63:0] lane,
   output logic        lane_valid,
   input  logic        lane_ready,
   output logic        lane_last,
   output logic [4:0]  lane_idx,
   output logic        dropped
);

   localparam logic [4:0] LAST_IDX = 5'(OUT_LANES - 1);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [4:0]  counter;
   logic [4:0]  counter_next;
   logic        transfer;
   logic        capture;
   logic        at_last;
   logic [63:0] in_lanes [25];
   logic [63:0] buffer   [25];

   // Rows are flattened so that linear lane index k = 5*y + x.
   always_comb begin
      for (int x = 0; x < 5; x++) begin
         in_lanes[x]      = isa[x];
         in_lanes[5 + x]  = isb[x];
         in_lanes[10 + x] = isc[x];
         in_lanes[15 + x] = isd[x];
         in_lanes[20 + x] = ise[x];
      end
   end

   always_comb begin
      lane_valid   = (state == STREAM);
      at_last      = (counter == LAST_IDX);
      lane_last    = lane_valid & at_last;
      transfer     = lane_valid & lane_ready;
      accept       = (state == IDLE) | (transfer & at_last);
      capture      = sample & accept;
      state_next   = state;
      counter_next = counter;
      case (state)
         IDLE: begin
            if (capture) begin
               state_next   = STREAM;
               counter_next = '0;
            end
         end
         STREAM: begin
            if (transfer) begin
               if (!at_last) begin
                  counter_next = counter + 5'd1;
               end else if (capture) begin
                  counter_next = '0;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         counter <= '0;
         dropped <= 1'b0;
      end else begin
         state   <= state_next;
         counter <= counter_next;
         if (sample && !accept) begin
            dropped <= 1'b1;
         end
      end
   end

   // The buffer only moves on a capture, so stalled lanes stay put.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 25; k++) begin
            buffer[k] <= '0;
         end
      end else if (capture) begin
         for (int k = 0; k < 25; k++) begin
            buffer[k] <= in_lanes[k];
         end
      end
   end

   assign lane     = buffer[counter];
   assign lane_idx = counter;

endmodule
